// File: rtl/arena_if.sv
// rtl/arena_if.sv - arena sweep request and RAM write port bundle
interface arena_if;
    logic        start;
    logic [18:0] wraddress;
    logic [7:0]  data;
    logic        wren;
    logic        busy;
    logic        done;

    modport master (
        input  start,
        output wraddress, data, wren, busy, done
    );

    modport slave (
        output start,
        input  wraddress, data, wren, busy, done
    );
endinterface

// File: rtl/arena_init.sv
// rtl/arena_init.sv - clears the arena RAM, paints the border and seeds both player squares
module arena_init #(
    parameter int H_RES          = 640,
    parameter int V_RES          = 480,
    parameter int MARGIN         = 16,
    parameter int P1_X           = 216,
    parameter int P2_X           = 424,
    parameter int START_Y        = 240,
    parameter int SQ             = 8,
    parameter logic [7:0] CODE_BORDER = 8'h02,
    parameter logic [7:0] CODE_P1     = 8'h01,
    parameter logic [7:0] CODE_P2     = 8'h80
) (
    input  logic   CLOCK_50,
    input  logic   reset,
    arena_if.master bus
);
    localparam int AW = 19;
    localparam int XW = (H_RES > 2) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 2) ? $clog2(V_RES) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);
    localparam logic [XW-1:0] X_LO   = XW'(MARGIN);
    localparam logic [XW-1:0] X_HI   = XW'(H_RES - 1 - MARGIN);
    localparam logic [YW-1:0] Y_LO   = YW'(MARGIN);
    localparam logic [YW-1:0] Y_HI   = YW'(V_RES - 1 - MARGIN);
    localparam logic [XW-1:0] SQ_XL  = XW'(SQ - 1);
    localparam logic [YW-1:0] SQ_YL  = YW'(SQ - 1);
    localparam logic [AW-1:0] ROW    = AW'(H_RES);
    localparam logic [AW-1:0] P1_BASE = AW'(START_Y * H_RES + P1_X);
    localparam logic [AW-1:0] P2_BASE = AW'(START_Y * H_RES + P2_X);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SEED_P1,
        SEED_P2,
        DONE
    } state_t;

    state_t         state, state_n;
    logic [XW-1:0]  cx, cx_n;
    logic [YW-1:0]  cy, cy_n;
    logic [AW-1:0]  base, base_n;
    logic [AW-1:0]  addr_q, addr_n;
    logic [7:0]     data_q, data_n;
    logic           wren_q, wren_n;
    logic           busy_q, busy_n;
    logic           done_q, done_n;

    function automatic logic is_border(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return (x < X_LO) || (x > X_HI) || (y < Y_LO) || (y > Y_HI);
    endfunction

    // cx/cy/base always describe the write currently on the outputs; in the
    // seed states they are square-local column/row and the row's start address.
    always_comb begin
        state_n = state;
        cx_n    = cx;
        cy_n    = cy;
        base_n  = base;
        addr_n  = addr_q;
        data_n  = data_q;
        wren_n  = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = CLEAR;
                    cx_n    = '0;
                    cy_n    = '0;
                    base_n  = '0;
                    addr_n  = '0;
                    data_n  = is_border('0, '0) ? CODE_BORDER : 8'h00;
                    wren_n  = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            CLEAR: begin
                wren_n = 1'b1;
                busy_n = 1'b1;
                if (cx == X_LAST && cy == Y_LAST) begin
                    state_n = SEED_P1;
                    cx_n    = '0;
                    cy_n    = '0;
                    base_n  = P1_BASE;
                    addr_n  = P1_BASE;
                    data_n  = CODE_P1;
                end else begin
                    if (cx == X_LAST) begin
                        cx_n   = '0;
                        cy_n   = cy + 1'b1;
                        base_n = base + ROW;
                    end else begin
                        cx_n   = cx + 1'b1;
                    end
                    addr_n = base_n + AW'(cx_n);
                    data_n = is_border(cx_n, cy_n) ? CODE_BORDER : 8'h00;
                end
            end
            SEED_P1, SEED_P2: begin
                wren_n = 1'b1;
                busy_n = 1'b1;
                data_n = (state == SEED_P1) ? CODE_P1 : CODE_P2;
                if (cx == SQ_XL && cy == SQ_YL) begin
                    if (state == SEED_P1) begin
                        state_n = SEED_P2;
                        cx_n    = '0;
                        cy_n    = '0;
                        base_n  = P2_BASE;
                        addr_n  = P2_BASE;
                        data_n  = CODE_P2;
                    end else begin
                        state_n = DONE;
                        wren_n  = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        data_n  = data_q;
                    end
                end else begin
                    if (cx == SQ_XL) begin
                        cx_n   = '0;
                        cy_n   = cy + 1'b1;
                        base_n = base + ROW;
                    end else begin
                        cx_n   = cx + 1'b1;
                    end
                    addr_n = base_n + AW'(cx_n);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state  <= IDLE;
            cx     <= '0;
            cy     <= '0;
            base   <= '0;
            addr_q <= '0;
            data_q <= '0;
            wren_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cx     <= cx_n;
            cy     <= cy_n;
            base   <= base_n;
            addr_q <= addr_n;
            data_q <= data_n;
            wren_q <= wren_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

    assign bus.wraddress = addr_q;
    assign bus.data      = data_q;
    assign bus.wren      = wren_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
